// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared types and constants for the IO bridge slave-side front end
package io_bridge_pkg;

    // Bridge slave port geometry
    localparam int IO_ADDR_W      = 6;
    localparam int IO_DATA_W      = 32;
    localparam int IO_BURST_W     = 5;

    // Read words that may be reserved but not yet returned; sized to the bridge response FIFO
    localparam int IO_MAX_PENDING = 16;
    localparam int IO_PEND_W      = 5;

    // Burst splitter control states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } burst_state_t;

endpackage

// File: rtl/io_read_credit_counter.sv
// rtl/io_read_credit_counter.sv - outstanding read-word counter with reserve, return and floor at zero
module io_read_credit_counter
    import io_bridge_pkg::*;
#(
    parameter int MAX_PENDING = IO_MAX_PENDING,
    parameter int PEND_W      = IO_PEND_W,
    parameter int CNT_W       = IO_BURST_W
) (
    input  logic              slave_clk,
    input  logic              slave_reset_n,
    input  logic              reserve,
    input  logic [CNT_W-1:0]  request_count,
    input  logic              word_returned,
    output logic              has_credit,
    output logic [PEND_W-1:0] pending
);

    logic [31:0] request_total;
    logic [31:0] pending_next;

    // A request fits when the words already in flight plus the new burst stay within the FIFO depth
    always_comb begin
        request_total = 32'(pending) + 32'(request_count);
        has_credit    = (request_total <= 32'(MAX_PENDING));
    end

    // Reserve first, then retire one returned word; a stray return at zero leaves the count at zero
    always_comb begin
        pending_next = 32'(pending);
        if (reserve) begin
            pending_next = pending_next + 32'(request_count);
        end
        if (word_returned && (pending_next != 32'd0)) begin
            pending_next = pending_next - 32'd1;
        end
    end

    // Counter register; cleared with the bridge, which flushes its in-flight words on the same reset
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            pending <= '0;
        end else begin
            pending <= PEND_W'(pending_next);
        end
    end

endmodule

// File: rtl/io_burst_splitter.sv
// rtl/io_burst_splitter.sv - splits Avalon-MM bursts into single-word bridge transfers with read credit throttling
module io_burst_splitter
    import io_bridge_pkg::*;
#(
    parameter int ADDR_W      = IO_ADDR_W,
    parameter int DATA_W      = IO_DATA_W,
    parameter int BURST_W     = IO_BURST_W,
    parameter int MAX_PENDING = IO_MAX_PENDING,
    parameter int PEND_W      = IO_PEND_W
) (
    input  logic               slave_clk,
    input  logic               slave_reset_n,
    input  logic [ADDR_W-1:0]  s_address,
    input  logic [BURST_W-1:0] s_burstcount,
    input  logic [3:0]         s_byteenable,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [DATA_W-1:0]  s_writedata,
    output logic               s_waitrequest,
    output logic [DATA_W-1:0]  s_readdata,
    output logic               s_readdatavalid,
    output logic               s_endofpacket,
    output logic [ADDR_W-1:0]  m_address,
    output logic [ADDR_W-1:0]  m_nativeaddress,
    output logic [3:0]         m_byteenable,
    output logic               m_read,
    output logic               m_write,
    output logic [DATA_W-1:0]  m_writedata,
    input  logic               m_waitrequest,
    input  logic [DATA_W-1:0]  m_readdata,
    input  logic               m_readdatavalid,
    input  logic               m_endofpacket
);

    burst_state_t       state;
    burst_state_t       state_next;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         be_q;
    logic [BURST_W-1:0] beats_q;
    logic [BURST_W-1:0] burst_eff;
    logic [PEND_W-1:0]  pending;
    logic               has_credit;
    logic               rd_accept;
    logic               wr_start;
    logic               rd_beat;
    logic               wr_beat;
    logic               last_beat;

    // A zero burstcount is treated as a single word
    assign burst_eff = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;

    // Read wins over a simultaneous write; the reset term keeps waitrequest high while reset is held
    assign rd_accept = slave_reset_n && (state == IDLE) && s_read && has_credit;
    assign wr_start  = (state == IDLE) && !s_read && s_write;
    assign rd_beat   = (state == RD_BURST) && !m_waitrequest;
    assign wr_beat   = (state == WR_BURST) && s_write && !m_waitrequest;
    assign last_beat = (beats_q == BURST_W'(1));

    io_read_credit_counter #(
        .MAX_PENDING (MAX_PENDING),
        .PEND_W      (PEND_W),
        .CNT_W       (BURST_W)
    ) u_credit (
        .slave_clk     (slave_clk),
        .slave_reset_n (slave_reset_n),
        .reserve       (rd_accept),
        .request_count (burst_eff),
        .word_returned (m_readdatavalid),
        .has_credit    (has_credit),
        .pending       (pending)
    );

    // State register; reset drops any burst in progress at once
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: a burst ends on the completion of its last beat
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_accept) begin
                    state_next = RD_BURST;
                end else if (wr_start) begin
                    state_next = WR_BURST;
                end
            end
            RD_BURST: begin
                if (rd_beat && last_beat) begin
                    state_next = IDLE;
                end
            end
            WR_BURST: begin
                if (wr_beat && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fabric/bridge handshakes; a write burst passes data and backpressure straight through
    always_comb begin
        s_waitrequest = 1'b1;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = s_writedata;
        case (state)
            IDLE:     s_waitrequest = !rd_accept;
            RD_BURST: m_read        = 1'b1;
            WR_BURST: begin
                m_write       = s_write;
                s_waitrequest = m_waitrequest;
            end
            default: begin
                s_waitrequest = 1'b1;
            end
        endcase
    end

    // Burst command latch and per-beat address/count stepping; the address wraps at the top of the window
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            addr_q  <= '0;
            be_q    <= '0;
            beats_q <= '0;
        end else if (rd_accept || wr_start) begin
            addr_q  <= s_address;
            be_q    <= s_byteenable;
            beats_q <= burst_eff;
        end else if (rd_beat || wr_beat) begin
            addr_q  <= addr_q + ADDR_W'(1);
            beats_q <= beats_q - BURST_W'(1);
        end
    end

    assign m_address       = addr_q;
    assign m_nativeaddress = addr_q;
    assign m_byteenable    = be_q;

    // Read return path: one register stage from the bridge back to the fabric
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            s_readdata      <= '0;
            s_readdatavalid <= 1'b0;
            s_endofpacket   <= 1'b0;
        end else begin
            s_readdata      <= m_readdata;
            s_readdatavalid <= m_readdatavalid;
            s_endofpacket   <= m_endofpacket;
        end
    end

endmodule

// File: tb/tb_io_burst_splitter.sv
// tb/tb_io_burst_splitter.sv - self-checking bench for io_burst_splitter
module tb_io_burst_splitter;

    logic        slave_clk = 1'b0;
    logic        slave_reset_n;
    logic [5:0]  s_address;
    logic [4:0]  s_burstcount;
    logic [3:0]  s_byteenable;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic        s_endofpacket;
    logic [5:0]  m_address;
    logic [5:0]  m_nativeaddress;
    logic [3:0]  m_byteenable;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic        m_endofpacket;

    io_burst_splitter dut (
        .slave_clk       (slave_clk),
        .slave_reset_n   (slave_reset_n),
        .s_address       (s_address),
        .s_burstcount    (s_burstcount),
        .s_byteenable    (s_byteenable),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .s_endofpacket   (s_endofpacket),
        .m_address       (m_address),
        .m_nativeaddress (m_nativeaddress),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_endofpacket   (m_endofpacket)
    );

    always #5 slave_clk = ~slave_clk;

    typedef struct {
        logic [5:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        bit          is_rd;
        logic [5:0]  addr;
        logic [4:0]  bc;
        logic [3:0]  be;
        logic [31:0] base;
        int          stall_beat;
        int          stall_len;
        int          exp_beats;
        logic [5:0]  exp_end;
        int          exp_pend;
    } vec_t;

    xfer_t       exp_rd[$];
    xfer_t       exp_wr[$];
    logic [32:0] exp_ret[$];
    int          total = 0;
    int          bad = 0;
    int          ret_ctr = 0;
    logic        prev_mrdv = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: bridge-side transfers against queued expectations, return path against one-cycle copies
    always @(negedge slave_clk) begin
        xfer_t       x;
        logic [32:0] r;
        if (slave_reset_n) begin
            if (m_read && !m_waitrequest) begin
                if (exp_rd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_extra: got read at %0h expected none", m_address);
                end else begin
                    x = exp_rd.pop_front();
                    check("rd_addr", 64'(m_address), 64'(x.addr));
                    check("rd_native", 64'(m_nativeaddress), 64'(x.addr));
                    check("rd_be", 64'(m_byteenable), 64'(x.be));
                end
            end
            if (m_write && !m_waitrequest) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_extra: got write at %0h expected none", m_address);
                end else begin
                    x = exp_wr.pop_front();
                    check("wr_addr", 64'(m_address), 64'(x.addr));
                    check("wr_be", 64'(m_byteenable), 64'(x.be));
                    check("wr_data", 64'(m_writedata), 64'(x.data));
                end
            end
            if (s_readdatavalid || prev_mrdv) begin
                check("rdv_latency", 64'(s_readdatavalid), 64'(prev_mrdv));
            end
            if (s_readdatavalid && exp_ret.size() != 0) begin
                r = exp_ret.pop_front();
                check("rdata", 64'(s_readdata), 64'(r[31:0]));
                check("rd_eop", 64'(s_endofpacket), 64'(r[32]));
            end
            if (m_readdatavalid) begin
                exp_ret.push_back({m_endofpacket, m_readdata});
            end
        end
        prev_mrdv <= slave_reset_n && m_readdatavalid;
    end

    task automatic rd_request(input logic [5:0] a, input logic [4:0] bc, input logic [3:0] be);
        bit ok;
        @(posedge slave_clk); #1;
        s_read       = 1'b1;
        s_address    = a;
        s_burstcount = bc;
        s_byteenable = be;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge slave_clk);
            if (!s_waitrequest) begin
                ok = 1'b1;
                break;
            end
            @(posedge slave_clk); #1;
        end
        check("rd_accept", 64'(ok), 64'(1));
    endtask

    task automatic rd_run(input logic [5:0] a, input logic [3:0] be, input int n,
                          input int stall_beat, input int stall_len, output int beats);
        xfer_t x;
        int    stalled;
        for (int i = 0; i < n; i++) begin
            x.addr = a + 6'(i);
            x.be   = be;
            x.data = '0;
            exp_rd.push_back(x);
        end
        beats = 0;
        stalled = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge slave_clk); #1;
            s_read          = 1'b0;
            m_readdatavalid = 1'b0;
            m_endofpacket   = 1'b0;
            if (beats == stall_beat && stalled < stall_len) begin
                m_waitrequest = 1'b1;
                stalled++;
            end else begin
                m_waitrequest = 1'b0;
            end
            @(negedge slave_clk);
            if (!m_read) break;
            if (!m_waitrequest) beats++;
        end
        m_waitrequest = 1'b0;
    endtask

    task automatic wr_run(input logic [5:0] a, input logic [4:0] bc, input logic [3:0] be,
                          input logic [31:0] base, input int n, input int stall_beat,
                          input int stall_len, output int beats);
        xfer_t x;
        int    stalled;
        bit    stall;
        for (int i = 0; i < n; i++) begin
            x.addr = a + 6'(i);
            x.be   = be;
            x.data = base + 32'(i);
            exp_wr.push_back(x);
        end
        @(posedge slave_clk); #1;
        s_write       = 1'b1;
        s_address     = a;
        s_burstcount  = bc;
        s_byteenable  = be;
        s_writedata   = base;
        m_waitrequest = 1'b0;
        beats = 0;
        stalled = 0;
        stall = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge slave_clk);
            if (stall) check("wr_wait_mirror", 64'(s_waitrequest), 64'(1));
            else if (!s_waitrequest) beats++;
            if (beats >= n) break;
            @(posedge slave_clk); #1;
            s_writedata = base + 32'(beats);
            stall = (beats == stall_beat) && (stalled < stall_len);
            if (stall) stalled++;
            m_waitrequest = stall;
        end
        @(posedge slave_clk); #1;
        s_write       = 1'b0;
        m_waitrequest = 1'b0;
    endtask

    task automatic return_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge slave_clk); #1;
            m_readdatavalid = 1'b1;
            m_readdata      = 32'hD000_0000 + 32'(ret_ctr);
            m_endofpacket   = (i == n - 1);
            ret_ctr++;
        end
        @(posedge slave_clk); #1;
        m_readdatavalid = 1'b0;
        m_endofpacket   = 1'b0;
        @(negedge slave_clk);
    endtask

    task automatic one_return();
        @(posedge slave_clk); #1;
        m_readdatavalid = 1'b1;
        m_readdata      = 32'hD000_0000 + 32'(ret_ctr);
        m_endofpacket   = 1'b0;
        ret_ctr++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   beats;
        bit   taken;

        vecs[0] = '{1'b1, 6'h3E, 5'd4,  4'hF, 32'h0,         -1, 0, 4,  6'h02, 4};
        vecs[1] = '{1'b0, 6'h10, 5'd3,  4'hF, 32'hA000_0000,  1, 2, 3,  6'h13, 0};
        vecs[2] = '{1'b1, 6'h05, 5'd0,  4'h3, 32'h0,         -1, 0, 1,  6'h06, 1};
        vecs[3] = '{1'b0, 6'h3F, 5'd2,  4'hC, 32'h1234_0000, -1, 0, 2,  6'h01, 0};
        vecs[4] = '{1'b1, 6'h20, 5'd16, 4'hF, 32'h0,          5, 3, 16, 6'h30, 16};
        vecs[5] = '{1'b0, 6'h00, 5'd0,  4'h1, 32'hFFFF_FFF0, -1, 0, 1,  6'h01, 0};

        slave_reset_n   = 1'b0;
        s_address       = '0;
        s_burstcount    = '0;
        s_byteenable    = '0;
        s_read          = 1'b0;
        s_write         = 1'b0;
        s_writedata     = '0;
        m_waitrequest   = 1'b0;
        m_readdata      = '0;
        m_readdatavalid = 1'b0;
        m_endofpacket   = 1'b0;

        #12;
        check("rst_waitreq", 64'(s_waitrequest), 64'(1));
        check("rst_m_read", 64'(m_read), 64'(0));
        check("rst_m_write", 64'(m_write), 64'(0));
        check("rst_rdv", 64'(s_readdatavalid), 64'(0));
        check("rst_rdata", 64'(s_readdata), 64'(0));
        check("rst_eop", 64'(s_endofpacket), 64'(0));
        check("rst_m_addr", 64'(m_address), 64'(0));
        check("rst_pending", 64'(dut.pending), 64'(0));
        @(posedge slave_clk); #1;
        slave_reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].is_rd) begin
                rd_request(vecs[v].addr, vecs[v].bc, vecs[v].be);
                rd_run(vecs[v].addr, vecs[v].be, vecs[v].exp_beats,
                       vecs[v].stall_beat, vecs[v].stall_len, beats);
                check($sformatf("vec%0d_beats", v), 64'(beats), 64'(vecs[v].exp_beats));
                check($sformatf("vec%0d_end", v), 64'(m_address), 64'(vecs[v].exp_end));
                check($sformatf("vec%0d_pend", v), 64'(dut.pending), 64'(vecs[v].exp_pend));
                return_words(vecs[v].exp_beats);
                check($sformatf("vec%0d_drain", v), 64'(dut.pending), 64'(0));
            end else begin
                wr_run(vecs[v].addr, vecs[v].bc, vecs[v].be, vecs[v].base, vecs[v].exp_beats,
                       vecs[v].stall_beat, vecs[v].stall_len, beats);
                @(negedge slave_clk);
                check($sformatf("vec%0d_beats", v), 64'(beats), 64'(vecs[v].exp_beats));
                check($sformatf("vec%0d_end", v), 64'(m_address), 64'(vecs[v].exp_end));
                check($sformatf("vec%0d_idle", v), 64'(m_write), 64'(0));
            end
        end

        // Credit limit: 14 outstanding, a 4-word burst waits for two returns
        rd_request(6'h00, 5'd14, 4'hF);
        rd_run(6'h00, 4'hF, 14, -1, 0, beats);
        check("credit_fill_pend", 64'(dut.pending), 64'(14));
        @(posedge slave_clk); #1;
        s_read       = 1'b1;
        s_address    = 6'h30;
        s_burstcount = 5'd4;
        s_byteenable = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge slave_clk);
            check("credit_hold", 64'(s_waitrequest), 64'(1));
            check("credit_no_read", 64'(m_read), 64'(0));
            if (k < 2) begin
                @(posedge slave_clk); #1;
            end
        end
        one_return();
        @(negedge slave_clk);
        check("credit_hold_r1", 64'(s_waitrequest), 64'(1));
        @(posedge slave_clk); #1;
        m_readdatavalid = 1'b0;
        @(negedge slave_clk);
        check("credit_hold_13", 64'(s_waitrequest), 64'(1));
        one_return();
        @(negedge slave_clk);
        check("credit_hold_r2", 64'(s_waitrequest), 64'(1));
        @(posedge slave_clk); #1;
        m_readdatavalid = 1'b0;
        @(negedge slave_clk);
        check("credit_accept", 64'(s_waitrequest), 64'(0));
        rd_run(6'h30, 4'hF, 4, -1, 0, beats);
        check("credit_beats", 64'(beats), 64'(4));
        check("credit_full_pend", 64'(dut.pending), 64'(16));
        return_words(16);
        check("credit_drain", 64'(dut.pending), 64'(0));

        // Same-cycle accept of a 2-word burst and a returned word at pending 5
        rd_request(6'h08, 5'd5, 4'hF);
        rd_run(6'h08, 4'hF, 5, -1, 0, beats);
        check("same_pend5", 64'(dut.pending), 64'(5));
        @(posedge slave_clk); #1;
        s_read          = 1'b1;
        s_address       = 6'h18;
        s_burstcount    = 5'd2;
        s_byteenable    = 4'hF;
        m_readdatavalid = 1'b1;
        m_readdata      = 32'hD000_0000 + 32'(ret_ctr);
        ret_ctr++;
        @(negedge slave_clk);
        check("same_accept", 64'(s_waitrequest), 64'(0));
        rd_run(6'h18, 4'hF, 2, -1, 0, beats);
        check("same_beats", 64'(beats), 64'(2));
        check("same_pend6", 64'(dut.pending), 64'(6));
        return_words(6);
        check("same_drain", 64'(dut.pending), 64'(0));

        // Reset during beat 2 of an 8-word read
        rd_request(6'h28, 5'd8, 4'hF);
        for (int i = 0; i < 8; i++) begin
            exp_rd.push_back('{6'h28 + 6'(i), 4'hF, 32'h0});
        end
        beats = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge slave_clk); #1;
            s_read = 1'b0;
            @(negedge slave_clk);
            if (m_read && !m_waitrequest) beats++;
            if (beats >= 2 || !m_read) break;
        end
        check("abort_beats", 64'(beats), 64'(2));
        #2;
        slave_reset_n = 1'b0;
        exp_rd.delete();
        #1;
        check("abort_m_read", 64'(m_read), 64'(0));
        check("abort_pending", 64'(dut.pending), 64'(0));
        check("abort_waitreq", 64'(s_waitrequest), 64'(1));
        check("abort_m_addr", 64'(m_address), 64'(0));
        repeat (2) begin
            @(negedge slave_clk);
            check("abort_quiet", 64'(m_read), 64'(0));
        end
        @(posedge slave_clk); #1;
        slave_reset_n = 1'b1;
        rd_request(6'h3C, 5'd3, 4'h6);
        rd_run(6'h3C, 4'h6, 3, -1, 0, beats);
        check("post_rst_beats", 64'(beats), 64'(3));
        check("post_rst_end", 64'(m_address), 64'(6'h3F));
        check("post_rst_pend", 64'(dut.pending), 64'(3));
        return_words(3);
        check("post_rst_drain", 64'(dut.pending), 64'(0));

        // Read and write requested together: read first, then the write
        @(posedge slave_clk); #1;
        s_read       = 1'b1;
        s_write      = 1'b1;
        s_address    = 6'h2A;
        s_burstcount = 5'd1;
        s_byteenable = 4'hF;
        s_writedata  = 32'h5A5A_0001;
        exp_rd.push_back('{6'h2A, 4'hF, 32'h0});
        exp_wr.push_back('{6'h2A, 4'hF, 32'h5A5A_0001});
        @(negedge slave_clk);
        check("both_read_first", 64'(s_waitrequest), 64'(0));
        @(posedge slave_clk); #1;
        s_read = 1'b0;
        @(negedge slave_clk);
        check("both_m_read", 64'(m_read), 64'(1));
        check("both_no_write", 64'(m_write), 64'(0));
        taken = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge slave_clk); #1;
            @(negedge slave_clk);
            if (m_write && !s_waitrequest) begin
                taken = 1'b1;
                break;
            end
        end
        check("both_write_done", 64'(taken), 64'(1));
        @(posedge slave_clk); #1;
        s_write = 1'b0;
        return_words(1);
        check("both_drain", 64'(dut.pending), 64'(0));

        repeat (3) @(negedge slave_clk);
        check("rd_queue_empty", 64'(exp_rd.size()), 64'(0));
        check("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
        check("ret_queue_empty", 64'(exp_ret.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
